counter_up60: RTL and testbench
===============================

Name: counter_up60

Overview:
- Two-digit BCD seconds up-counter, 00→59→00, for the stopwatch path of the timer. It is the counting-up counterpart of the timer's countdown seconds digits.
- Ones digit is mod-10 and tens digit is mod-(MAX_TENS+1). The block loads a preset, counts while enabled and emits an active-low ripple-carry on wrap.
- The ripple-carry drives the enable of the next (minutes) stage.

Parameters:
- MAX_TENS, 5: terminal tens value. 5 gives mod-60; other values reuse the block, e.g. 9 gives mod-100.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous reset, active-high
- enablen  input  1  count enable, active-low
- load  input  1  synchronous preset strobe, active-high
- in_tens  input  4  preset tens digit
- in_ones  input  4  preset ones digit
- count_tens  output  4  current tens digit (registered)
- count_ones  output  4  current ones digit (registered)
- rco_L  output  1  ripple-carry out, active-low (combinational)
- done  output  1  saturation flag; driven 0 unless COUNTER_UP60_SATURATE_EN

Behaviour:
- Reset: rst=1 immediately forces count_tens=0 and count_ones=0, regardless of clk. rco_L=1 and done=0 follow from that state. Reset mid-count aborts the count with no partial update. The first edge after deassertion behaves normally.
- Priority at posedge clk: rst > load > count > hold.
- Load:
  - load=1 captures in_tens and in_ones unmodified on the next edge, even if enablen=1.
  - Values above the terminal (tens 6..9, ones A..F) are accepted.
- Count: when load=0 and enablen=0, the counter advances one step per edge.
  - Ones digit: if count_ones>=9, next ones=0 and the tens digit advances. Otherwise ones+1.
  - Tens digit, advanced only on ones wrap: if count_tens==MAX_TENS or count_tens>=9, next tens=0 (wrap). Otherwise tens+1.
  - So a preset of 60..99 counts up to 99, then wraps to 00. Invalid ones values A..F wrap to 0 on the next count.
- Hold: when enablen=1 and load=0, both digits hold.
- Terminal state T: count_ones>=9 AND (count_tens==MAX_TENS OR count_tens>=9).
- rco_L = !(T && !enablen && !load), combinational.
  - rco_L is low for exactly the cycle whose edge performs the wrap to 00.
  - load in the same cycle suppresses rco_L, and no wrap occurs.
- Latency: count and load take effect 1 clk after the edge. rco_L has zero latency from state or enablen.
- Chaining: the next stage's enablen is connected to this rco_L.

Optional Feature:
- Macro: COUNTER_UP60_SATURATE_EN.
- Defined:
  - At T with enablen=0, the counter holds at its value instead of wrapping. done goes high from the edge that would have wrapped and stays high until load or rst.
  - rco_L remains 1 permanently; no carry is generated.
  - load clears done on the same edge it loads.
- Undefined: wrap behaviour as above; done is tied 0.

Decomposition:
- Shared package (timer_pkg):
  - BCD digit width constant DIGIT_W=4.
  - Constants BCD_ZERO=4'd0, BCD_NINE=4'd9.
  - Default seconds terminal tens SEC_MAX_TENS=5.
  - These are shared with the countdown digits.
- One sub-module, bcd_digit_up, instantiated twice (ones limit 9, tens limit MAX_TENS).
  - Function: single 4-bit up-digit with load, enable and wrap.
  - Outputs: count and a terminal flag.
  - The top level ANDs the terminal flags and forms rco_L/done.

Test Plan:
- Reset: assert rst mid-count at 37, between clock edges → count 00 immediately, rco_L=1; release, enablen=0 → 01 after 1 edge.
- Full cycle: from 00, enablen=0 for 60 edges → passes 09→10 and 58→59. rco_L=0 only while at 59, then 00 is reached with exactly one rco_L pulse.
- Load and hold:
  - enablen=1, load=1 with in=4,7 → 47.
  - Hold 5 edges → still 47.
  - load and enablen=0 in the same cycle with in=2,3 → 23, not 48.
- Out-of-range preset:
  - load 7,5 then count → 76..99, then 00 with rco_L=0 at 99.
  - load 3,C → next count is 40.
- Carry suppression: at 59 with enablen=0 and load=1 (in=1,0) → rco_L=1 that cycle, next value 10.
- Saturate (COUNTER_UP60_SATURATE_EN defined): count to 59, 3 more enabled edges → stays 59, done=1, rco_L=1 throughout; load 0,0 → 00, done=0.

Source files
------------

// File: rtl/timer_pkg.sv
// Shared BCD digit constants and helpers for the timer's seconds/minutes digit counters.
package timer_pkg;

    localparam int DIGIT_W = 4;

    typedef logic [DIGIT_W-1:0] digit_t;

    localparam digit_t BCD_ZERO = 4'd0;
    localparam digit_t BCD_NINE = 4'd9;

    localparam int unsigned SEC_MAX_TENS = 5;

    // A digit is terminal at its own limit, and also at 9 or above.
    // That makes out-of-range presets roll over instead of running to 15.
    function automatic logic digit_at_terminal(input digit_t value, input digit_t limit);
        return (value == limit) || (value >= BCD_NINE);
    endfunction

endpackage

// File: rtl/bcd_digit_up.sv
// Single 4-bit BCD up-digit: synchronous load, step-enabled increment, wrap to zero at terminal.
module bcd_digit_up
    import timer_pkg::*;
#(
    parameter int unsigned LIMIT = 9
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   load,
    input  logic   step,
    input  digit_t preset,
    output digit_t count,
    output logic   term
);

    localparam digit_t LIMIT_D = digit_t'(LIMIT);

    always_comb begin
        term = digit_at_terminal(count, LIMIT_D);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= BCD_ZERO;
        end else if (load) begin
            count <= preset;
        end else if (step) begin
            count <= term ? BCD_ZERO : count + 4'd1;
        end
    end

endmodule

// File: rtl/counter_up60.sv
// Two-digit BCD seconds up-counter (00..59 by default) with preset load and active-low ripple carry.
// Build with COUNTER_UP60_SATURATE_EN defined to hold at the terminal value and raise done instead of wrapping.
module counter_up60
    import timer_pkg::*;
#(
    parameter int unsigned MAX_TENS = SEC_MAX_TENS
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enablen,
    input  logic               load,
    input  logic [DIGIT_W-1:0] in_tens,
    input  logic [DIGIT_W-1:0] in_ones,
    output logic [DIGIT_W-1:0] count_tens,
    output logic [DIGIT_W-1:0] count_ones,
    output logic               rco_L,
    output logic               done
);

    logic ones_term;
    logic tens_term;
    logic at_term;
    logic count_en;
    logic ones_step;
    logic tens_step;

    always_comb begin
        count_en = !enablen && !load;
        at_term  = ones_term && tens_term;
    end

`ifdef COUNTER_UP60_SATURATE_EN
    logic done_q;

    always_comb begin
        ones_step = count_en && !at_term;
        tens_step = ones_step && ones_term;
    end

    // done latches on the edge that would have wrapped; only load or reset clear it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done_q <= 1'b0;
        end else if (load) begin
            done_q <= 1'b0;
        end else if (count_en && at_term) begin
            done_q <= 1'b1;
        end
    end

    assign rco_L = 1'b1;
    assign done  = done_q;
`else
    always_comb begin
        ones_step = count_en;
        tens_step = ones_step && ones_term;
    end

    // Low for exactly the cycle whose edge wraps to 00; a same-cycle load suppresses it.
    assign rco_L = !(at_term && count_en);
    assign done  = 1'b0;
`endif

    bcd_digit_up #(
        .LIMIT (9)
    ) u_ones (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (ones_step),
        .preset (in_ones),
        .count  (count_ones),
        .term   (ones_term)
    );

    bcd_digit_up #(
        .LIMIT (MAX_TENS)
    ) u_tens (
        .clk    (clk),
        .rst    (rst),
        .load   (load),
        .step   (tens_step),
        .preset (in_tens),
        .count  (count_tens),
        .term   (tens_term)
    );

endmodule

// File: tb/tb_counter_up60.sv
// Directed bench for counter_up60: vector table plus hand-written reset, wrap and carry sequences.
// The saturate sequence replaces the wrap sequences when COUNTER_UP60_SATURATE_EN is defined.
module tb_counter_up60;

    logic       clk;
    logic       rst;
    logic       enablen;
    logic       load;
    logic [3:0] in_tens;
    logic [3:0] in_ones;
    logic [3:0] count_tens;
    logic [3:0] count_ones;
    logic       rco_L;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       load;
        logic       enablen;
        logic [3:0] in_tens;
        logic [3:0] in_ones;
        logic       exp_rco;
        logic [3:0] exp_tens;
        logic [3:0] exp_ones;
    } vec_t;

    vec_t vecs[17];

    counter_up60 #(
        .MAX_TENS (5)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enablen    (enablen),
        .load       (load),
        .in_tens    (in_tens),
        .in_ones    (in_ones),
        .count_tens (count_tens),
        .count_ones (count_ones),
        .rco_L      (rco_L),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_count(input string name, input int tens, input int ones);
        check({name, " tens"}, {4'd0, count_tens}, 8'(tens));
        check({name, " ones"}, {4'd0, count_ones}, 8'(ones));
    endtask

    // Asynchronous reset pulse placed between clock edges.
    task automatic pulse_reset();
        #2;
        rst = 1'b1;
        #1;
        check_count("async reset", 0, 0);
        check("async reset rco_L", {7'd0, rco_L}, 8'd1);
        check("async reset done", {7'd0, done}, 8'd0);
        #1;
        rst = 1'b0;
    endtask

    task automatic do_load(input int tens, input int ones);
        load    = 1'b1;
        enablen = 1'b1;
        in_tens = 4'(tens);
        in_ones = 4'(ones);
        tick();
        load = 1'b0;
    endtask

    initial begin
        int v;
        int t;
        int o;
        int pulses;

        vecs[0]  = '{1'b1, 1'b1, 4'd4, 4'd7, 1'b1, 4'd4, 4'd7};
        vecs[1]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 4'd7};
        vecs[2]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 4'd7};
        vecs[3]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 4'd7};
        vecs[4]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 4'd7};
        vecs[5]  = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd4, 4'd7};
        vecs[6]  = '{1'b1, 1'b0, 4'd2, 4'd3, 1'b1, 4'd2, 4'd3};
        vecs[7]  = '{1'b1, 1'b1, 4'd3, 4'hC, 1'b1, 4'd3, 4'hC};
        vecs[8]  = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd4, 4'd0};
        vecs[9]  = '{1'b1, 1'b1, 4'd5, 4'd8, 1'b1, 4'd5, 4'd8};
        vecs[10] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd5, 4'd9};
        vecs[11] = '{1'b1, 1'b0, 4'd1, 4'd0, 1'b1, 4'd1, 4'd0};
        vecs[12] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd1};
        vecs[13] = '{1'b1, 1'b1, 4'd0, 4'd9, 1'b1, 4'd0, 4'd9};
        vecs[14] = '{1'b0, 1'b0, 4'd0, 4'd0, 1'b1, 4'd1, 4'd0};
        vecs[15] = '{1'b1, 1'b1, 4'd5, 4'd9, 1'b1, 4'd5, 4'd9};
        vecs[16] = '{1'b0, 1'b1, 4'd0, 4'd0, 1'b1, 4'd5, 4'd9};

        rst     = 1'b1;
        enablen = 1'b1;
        load    = 1'b0;
        in_tens = 4'd0;
        in_ones = 4'd0;
        #3;
        check_count("power-on reset", 0, 0);
        check("power-on rco_L", {7'd0, rco_L}, 8'd1);
        check("power-on done", {7'd0, done}, 8'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 17; i++) begin
            load    = vecs[i].load;
            enablen = vecs[i].enablen;
            in_tens = vecs[i].in_tens;
            in_ones = vecs[i].in_ones;
            #1;
            check($sformatf("vec%0d rco_L", i), {7'd0, rco_L}, {7'd0, vecs[i].exp_rco});
            tick();
            check_count($sformatf("vec%0d", i), int'(vecs[i].exp_tens), int'(vecs[i].exp_ones));
            check($sformatf("vec%0d done", i), {7'd0, done}, 8'd0);
        end
        load    = 1'b0;
        enablen = 1'b1;

        // Reset while counting at 37, then resume counting.
        do_load(3, 7);
        check_count("preset 37", 3, 7);
        enablen = 1'b0;
        pulse_reset();
        tick();
        check_count("first count after reset", 0, 1);

`ifndef COUNTER_UP60_SATURATE_EN
        // Full mod-60 cycle from 00 with exactly one carry pulse at 59.
        pulse_reset();
        enablen = 1'b0;
        v = 0;
        pulses = 0;
        for (int i = 0; i < 60; i++) begin
            check($sformatf("cycle rco_L at %0d", v), {7'd0, rco_L}, (v == 59) ? 8'd0 : 8'd1);
            if (rco_L == 1'b0) pulses++;
            tick();
            v = (v + 1) % 60;
            check_count($sformatf("cycle value %0d", v), v / 10, v % 10);
        end
        check("carry pulses per cycle", 8'(pulses), 8'd1);

        // Out-of-range preset 75 runs to 99 and then wraps.
        do_load(7, 5);
        enablen = 1'b0;
        v = 75;
        pulses = 0;
        for (int i = 0; i < 25; i++) begin
            check($sformatf("high rco_L at %0d", v), {7'd0, rco_L}, (v == 99) ? 8'd0 : 8'd1);
            if (rco_L == 1'b0) pulses++;
            tick();
            v = (v + 1) % 100;
            check_count($sformatf("high value %0d", v), v / 10, v % 10);
        end
        check("high carry pulses", 8'(pulses), 8'd1);
        enablen = 1'b1;
`else
        // Saturation: hold at 59, raise done, never carry; load clears done.
        do_load(5, 7);
        enablen = 1'b0;
        tick();
        check_count("sat 58", 5, 8);
        check("sat rco_L at 58", {7'd0, rco_L}, 8'd1);
        tick();
        check_count("sat 59", 5, 9);
        check("sat done at 59", {7'd0, done}, 8'd0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sat rco_L hold%0d", i), {7'd0, rco_L}, 8'd1);
            tick();
            check_count($sformatf("sat hold%0d", i), 5, 9);
            check($sformatf("sat done hold%0d", i), {7'd0, done}, 8'd1);
        end
        do_load(0, 0);
        check_count("sat reload", 0, 0);
        check("sat done cleared", {7'd0, done}, 8'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
